// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the memory stage
// Holds the access-size and FSM-state enums plus the alignment-fault rule.
package mem_pkg;
   typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} mem_size_t;
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
   // Size encoding 3 is handled like WORD, so anything that is not BYTE or HALF needs word alignment.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      return (size == HALF) ? lane[0] : (size == BYTE) ? 1'b0 : (lane != 2'b00);
   endfunction
endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: data-memory bus between the memory stage and the memory
// master (stage) drives dmem_req/we/addr/wdata/be and receives dmem_rdata/ack.
// slave (memory) is the mirror image.
interface memory_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, input dmem_rdata, dmem_ack);
   modport slave  (input dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/load_align.sv
// load_align: extracts and extends the addressed load value from a 32-bit word
// Ports: size (BYTE/HALF/WORD), uns (zero-extend when 1), lane (addr[1:0]),
// rdata (raw memory word), data (aligned, extended result).
module load_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [1:0]  lane,
   input  logic [31:0] rdata,
   output logic [31:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b    = rdata[{lane, 3'b000} +: 8];
      h    = lane[1] ? rdata[31:16] : rdata[15:0];
      data = (size == BYTE) ? {{24{b[7] & ~uns}}, b} :
             (size == HALF) ? {{16{h[15] & ~uns}}, h} : rdata;
   end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage issuing loads/stores on a stalling data bus
// Ports: clk, rst_n (async active-low); execute-stage inputs ex_*/flush;
// dmem bus via memory_stage_if.master; mem_stall/misalign status;
// result/mem_data/wb_sel/write/rd towards writeback.
module memory_stage
   import mem_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  ex_valid,
   input  logic [31:0]           ex_result,
   input  logic [31:0]           ex_store_data,
   input  logic                  ex_mem_rd,
   input  logic                  ex_mem_wr,
   input  logic [1:0]            ex_size,
   input  logic                  ex_unsigned,
   input  logic                  ex_wb_sel,
   input  logic                  ex_write,
   input  logic [4:0]            ex_rd,
   memory_stage_if.master        dmem,
   output logic                  mem_stall,
   output logic                  misalign,
   output logic [31:0]           result,
   output logic [31:0]           mem_data,
   output logic                  wb_sel,
   output logic                  write,
   output logic [4:0]            rd
);
   state_t      state_q, state_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  size_q, size_d, lane_q, lane_d;
   logic        uns_q, uns_d, ld_q, ld_d, wr_lat_q, wr_lat_d, kill_q, kill_d;
   logic        wb_sel_q, wb_sel_d, write_q, write_d, misalign_q, misalign_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] result_q, result_d, mem_data_q, mem_data_d;
   logic        mem_op, accept, mis, go;
   logic [31:0] st_data, ld_data;
   logic [3:0]  st_be;

   load_align u_align (.size(size_q), .uns(uns_q), .lane(lane_q), .rdata(dmem.dmem_rdata), .data(ld_data));

   always_comb begin
      mem_op     = ex_mem_rd | ex_mem_wr;
      accept     = (state_q == IDLE) && ex_valid && !flush;
      mis        = misaligned(ex_size, ex_result[1:0]);
      go         = accept && mem_op && !mis;
      mem_stall  = (state_q == WAIT) || go;
      st_data    = (ex_size == BYTE) ? {4{ex_store_data[7:0]}} :
                   (ex_size == HALF) ? {2{ex_store_data[15:0]}} : ex_store_data;
      st_be      = (ex_size == BYTE) ? 4'b0001 << ex_result[1:0] :
                   (ex_size == HALF) ? 4'b0011 << {ex_result[1], 1'b0} : 4'hF;
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      size_d     = size_q;
      lane_d     = lane_q;
      uns_d      = uns_q;
      ld_d       = ld_q;
      wr_lat_d   = wr_lat_q;
      kill_d     = kill_q;
      wb_sel_d   = wb_sel_q;
      rd_d       = rd_q;
      result_d   = result_q;
      mem_data_d = mem_data_q;
      write_d    = 1'b0;
      misalign_d = accept && mem_op && mis;
      if (state_q == IDLE) begin
         if (accept && !mem_op) begin
            result_d = ex_result;
            wb_sel_d = ex_wb_sel;
            rd_d     = ex_rd;
            write_d  = ex_write;
         end
         if (go) begin
            state_d  = WAIT;
            req_d    = 1'b1;
            we_d     = ex_mem_wr;
            addr_d   = {ex_result[31:2], 2'b00};
            wdata_d  = st_data;
            be_d     = st_be;
            size_d   = ex_size;
            lane_d   = ex_result[1:0];
            uns_d    = ex_unsigned;
            ld_d     = ex_mem_rd;
            wr_lat_d = ex_write;
            wb_sel_d = ex_wb_sel;
            rd_d     = ex_rd;
            kill_d   = 1'b0;
         end
      end else begin
         // A flush in WAIT cannot cancel the bus cycle, so remember it to kill writeback.
         kill_d = kill_q | flush;
         if (dmem.dmem_ack) begin
            state_d = IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            kill_d  = 1'b0;
            write_d = wr_lat_q & ld_q & ~kill_q & ~flush;
            if (ld_q) mem_data_d = ld_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         size_q     <= '0;
         lane_q     <= '0;
         uns_q      <= 1'b0;
         ld_q       <= 1'b0;
         wr_lat_q   <= 1'b0;
         kill_q     <= 1'b0;
         wb_sel_q   <= 1'b0;
         rd_q       <= '0;
         result_q   <= '0;
         mem_data_q <= '0;
         write_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         size_q     <= size_d;
         lane_q     <= lane_d;
         uns_q      <= uns_d;
         ld_q       <= ld_d;
         wr_lat_q   <= wr_lat_d;
         kill_q     <= kill_d;
         wb_sel_q   <= wb_sel_d;
         rd_q       <= rd_d;
         result_q   <= result_d;
         mem_data_q <= mem_data_d;
         write_q    <= write_d;
         misalign_q <= misalign_d;
      end
   end

   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign dmem.dmem_be    = be_q;
   assign misalign        = misalign_q;
   assign result          = result_q;
   assign mem_data        = mem_data_q;
   assign wb_sel          = wb_sel_q;
   assign write           = write_q;
   assign rd              = rd_q;
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be clk and rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 flush  in  1  kill the instruction in this stage.
REQ-005 ex_valid  in  1  execute-stage instruction valid.
REQ-006 ex_result  in  32  ALU result; byte address for memory ops.
REQ-007 ex_store_data  in  32  store operand, right-justified.
REQ-008 ex_mem_rd / ex_mem_wr  in  1 each  load / store (never both).
REQ-009 ex_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as word.
REQ-010 ex_unsigned  in  1  zero-extend load when 1, sign-extend when 0.
REQ-011 ex_wb_sel / ex_write  in  1 each  writeback select and register-write enable.
REQ-012 ex_rd  in  5  destination register.
REQ-013 dmem_req / dmem_we  out  1 each  memory request / write strobe.
REQ-014 dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-015 dmem_wdata / dmem_be  out  32 / 4  store lanes / byte enables.
REQ-016 dmem_rdata / dmem_ack  in  32 / 1  read data / completion, valid in the same cycle.
REQ-017 mem_stall  out  1  freeze upstream stages.
REQ-018 misalign  out  1  one-cycle fault pulse.
REQ-019 result / mem_data  out  32 each  to writeback.
REQ-020 wb_sel / write / rd  out  1 / 1 / 5  to writeback.

Function
REQ-021 FSM states: IDLE and WAIT.
REQ-022 IDLE with ex_valid, no flush, and no memory op: result, wb_sel, rd and write (=ex_write) SHALL register on the next edge, giving one-cycle latency.
REQ-023 IDLE with ex_valid, no flush, and an aligned memory op: the block SHALL latch address/size/sign/rd/wb_sel/write, drive registered dmem_req=1 from the next cycle, and enter WAIT.
REQ-024 mem_stall SHALL be combinationally 1 in WAIT, and in IDLE when the condition of REQ-023 holds; it SHALL be 0 otherwise.
REQ-025 In WAIT, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL hold stable until dmem_ack; write output SHALL be 0 (bubble).
REQ-026 On dmem_ack in WAIT, on the same edge: state SHALL return to IDLE; dmem_req SHALL drop; mem_data SHALL capture the aligned and extended load data; write SHALL equal the latched write. A store SHALL produce write=0.
REQ-027 Load alignment: lane = addr[1:0] (little-endian). Byte takes rdata[8*lane+:8]; half takes rdata[16*addr[1]+:16]; the value is extended per ex_unsigned.
REQ-028 Store: byte replicates data[7:0] to 4 lanes, be=1<<lane; half replicates data[15:0], be=4'b0011<<addr[1]; word be=4'hF.
REQ-029 Misaligned access (half with addr[0]=1; word with addr[1:0]!=0) SHALL NOT issue a request; misalign=1 for one cycle; write=0.
REQ-030 Flush in IDLE: the incoming op SHALL be discarded (no request, write=0 next cycle).
REQ-031 Flush in WAIT: the bus transaction SHALL complete unchanged, and write SHALL be 0 at completion. A flush in the ack cycle SHALL also suppress write.
REQ-032 Outside completion and REQ-022 cycles, write SHALL be 0; result/mem_data hold their last values.

Reset
REQ-033 Reset: state=IDLE, dmem_req=0, dmem_we=0, write=0, misalign=0, mem_stall=0 (combinational consequence). All data registers SHALL clear to 0.
REQ-034 Reset asserted during WAIT SHALL abandon the transaction immediately. A dmem_ack arriving after reset in IDLE SHALL be ignored.

Structure
REQ-035 Package mem_pkg SHALL hold the mem_size_t enum (BYTE, HALF, WORD) and the state enum (IDLE, WAIT).
REQ-036 Sub-module load_align (combinational, size/unsigned/lane -> 32-bit extended data) SHALL perform REQ-027.

Verification
REQ-037 ALU op, ex_result=32'h1234, ex_write=1 -> next cycle result=32'h1234, write=1, mem_stall=0 throughout.
REQ-038 Signed byte load at addr 32'h103, rdata=32'h80FF_FF7F, ack after 3 wait cycles -> mem_stall=1 for 4 cycles; mem_data=32'hFFFF_FF80; write=1 one cycle after ack.
REQ-039 Half store at 32'h202, data 32'hABCD -> dmem_addr=32'h200, be=4'b1100, wdata=32'hABCD_ABCD, write=0 after ack.
REQ-040 Word load at 32'h101 -> no dmem_req, misalign=1 for one cycle, write=0, no stall.
REQ-041 flush asserted during WAIT of a word load -> dmem_req held until ack, write=0 on completion.
REQ-042 rst_n low during WAIT -> dmem_req=0 and state IDLE immediately; a later ack produces write=0.
